lsu_ctrl: RTL and testbench

//  Load/store unit for the MEM stage. It drives the data-memory request/grant/rvalid bus.
//  It aligns and sign-/zero-extends load data and produces ld_data_o, the load operand
//  of the writeback select. It holds the pipeline via lsu_stall_o until each access completes.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the MEM-stage load/store unit.
// Access-size encodings and controller state encoding.
package lsu_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane placement, byte enables, access legality
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  acc_funct3,
  input  logic        acc_we,
  input  logic [1:0]  acc_off,
  input  logic [31:0] acc_wdata,
  output logic        acc_bad,
  output logic [3:0]  acc_be,
  output logic [31:0] acc_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];

  // classify the access and replicate store data into its lanes
  always_comb begin
    acc_bad  = 1'b0;
    acc_be   = 4'b1111;
    acc_lane = acc_wdata;
    case (acc_funct3)
      LS_B: begin
        acc_lane = {4{acc_wdata[7:0]}};
        if (acc_we) begin
          acc_be = 4'b0001 << acc_off;
        end
      end
      LS_H: begin
        acc_bad  = acc_off[0];
        acc_lane = {2{acc_wdata[15:0]}};
        if (acc_we) begin
          acc_be = acc_off[1] ? 4'b1100 : 4'b0011;
        end
      end
      LS_W: begin
        acc_bad = |acc_off;
      end
      LS_BU: begin
        acc_bad = acc_we;
      end
      LS_HU: begin
        acc_bad = acc_we | acc_off[0];
      end
      default: begin
        acc_bad = 1'b1;
      end
    endcase
  end

  // pick the addressed byte/half of the read word and extend it
  always_comb begin
    ld_data = ld_rdata;
    case (ld_funct3)
      LS_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LS_H:  ld_data = {{16{ld_half[15]}}, ld_half};
      LS_BU: ld_data = {24'b0, ld_byte};
      LS_HU: ld_data = {16'b0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store controller driving the
// req/gnt/rvalid data bus and holding the pipeline per access.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  lsu_state_t    state_q;
  lsu_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic [29:0] waddr_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] ld_q;
  logic        mis_q;
  logic        err_q;

  logic        acc_bad;
  logic [3:0]  acc_be;
  logic [31:0] acc_lane;
  logic [31:0] ld_ext;

  logic take;
  logic accept;
  logic mis_d;
  logic err_d;
  logic ld_upd;
  logic in_req;

  lsu_align u_align (
    .acc_funct3 (lsu_funct3_i),
    .acc_we     (lsu_we_i),
    .acc_off    (lsu_addr_i[1:0]),
    .acc_wdata  (lsu_wdata_i),
    .acc_bad    (acc_bad),
    .acc_be     (acc_be),
    .acc_lane   (acc_lane),
    .ld_funct3  (funct3_q),
    .ld_off     (off_q),
    .ld_rdata   (dmem_rdata_i),
    .ld_data    (ld_ext)
  );

  // A fault pulse cycle releases the faulting instruction,
  // so its still-asserted valid must not start a new access.
  assign take = lsu_valid_i & ~mis_q & ~err_q;

  // next-state, timeout counter and event decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    ld_upd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          if (acc_bad) begin
            mis_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = RESP;
          ld_upd  = ~we_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, counter and one-cycle fault pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // capture the accepted access so bus fields hold until grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waddr_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      waddr_q  <= lsu_addr_i[31:2];
      we_q     <= lsu_we_i;
      funct3_q <= lsu_funct3_i;
      off_q    <= lsu_addr_i[1:0];
      be_q     <= acc_be;
      wdata_q  <= lsu_we_i ? acc_lane : '0;
    end
  end

  // load result is held until the next load completes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_q <= '0;
    end else if (ld_upd) begin
      ld_q <= ld_ext;
    end
  end

  assign in_req = (state_q == REQ);

  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req & we_q;
  assign dmem_addr_o  = in_req ? {waddr_q, 2'b00} : '0;
  assign dmem_wdata_o = in_req ? wdata_q : '0;
  assign dmem_be_o    = in_req ? be_q : '0;

  // A misaligned request also holds for its own cycle, so the
  // faulting instruction is still in MEM when misalign_o fires.
  assign lsu_stall_o = ((state_q == IDLE) & take)
                     | in_req
                     | (state_q == WAIT);

  assign ld_valid_o = (state_q == RESP) & ~we_q;
  assign ld_data_o  = ld_q;
  assign misalign_o = mis_q;
  assign bus_err_o  = err_q;

  // a response while the request is still pending is a bus fault
  a_rvalid_in_req : assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(dmem_req_o && dmem_rvalid_i)
  );

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed table, reset-in-flight sequence and
// randomized accesses against a transaction-level model.
module tb_lsu_ctrl;

  localparam int T = 20;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_valid_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_funct3_i = 3'b0;
  logic [31:0] lsu_addr_i = 32'b0;
  logic [31:0] lsu_wdata_i = 32'b0;
  logic        lsu_stall_o;
  logic [31:0] ld_data_o;
  logic        ld_valid_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'b0;

  always #5 clk_i = ~clk_i;

  lsu_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_we_i      (lsu_we_i),
    .lsu_funct3_i  (lsu_funct3_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .lsu_stall_o   (lsu_stall_o),
    .ld_data_o     (ld_data_o),
    .ld_valid_o    (ld_valid_o),
    .misalign_o    (misalign_o),
    .bus_err_o     (bus_err_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gdly;
    int          rdly;
    int          norv;
  } vec_t;

  typedef struct {
    int          mis;
    int          err;
    int          stall;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } row_t;

  typedef struct {
    int          stall;
    int          req;
    int          ldv;
    int          mis;
    int          err;
    int          unstable;
    int          hung;
    logic [31:0] ld_pulse;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
  } obs_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_ld = 32'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // expected outcome of one access, from size/offset arithmetic
  function automatic exp_t model(input vec_t v, input logic [31:0] prev);
    exp_t   e;
    int     sz;
    int     off;
    int     sgn;
    int     ok;
    longint val;
    longint lim;
    e.mis = 0;
    e.err = 0;
    e.stall = 0;
    e.be = 4'b0;
    e.wd = 32'b0;
    e.ld = prev;
    off = int'(v.addr[1:0]);
    sz = 1;
    sgn = 0;
    ok = 1;
    case (v.f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: begin sz = 4; sgn = 1; end
      3'd4: begin sz = 1; ok = v.we ? 0 : 1; end
      3'd5: begin sz = 2; ok = v.we ? 0 : 1; end
      default: ok = 0;
    endcase
    if (ok == 0 || (off % sz) != 0) begin
      e.mis = 1;
      e.stall = 1;
      return e;
    end
    e.be = v.we ? 4'(((1 << sz) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) begin
      e.wd[8*i +: 8] = v.wdata[8*(i % sz) +: 8];
    end
    e.err = v.norv;
    e.stall = 1 + (v.gdly + 1) + ((v.norv != 0) ? T : v.rdly + 1);
    if (!v.we && v.norv == 0) begin
      lim = longint'(1) << (8 * sz);
      val = longint'(v.rdata >> (8 * off)) & (lim - 1);
      if (sgn != 0 && val >= (lim >> 1)) val = val - lim;
      e.ld = val[31:0];
    end
    return e;
  endfunction

  // drive one access with a pipeline that holds valid while stalled
  // and a bus that grants/acks after the requested delays
  task automatic run_op(input vec_t v, output obs_t o);
    int pend;
    int granted;
    int rv_done;
    int rq;
    int wt;
    int tail;
    pend = 1;
    granted = 0;
    rv_done = 0;
    rq = 0;
    wt = 0;
    tail = 0;
    o = '{default: 0};
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      lsu_valid_i = (pend != 0);
      if (pend != 0) begin
        lsu_we_i = v.we;
        lsu_funct3_i = v.f3;
        lsu_addr_i = v.addr;
        lsu_wdata_i = v.wdata;
      end else begin
        lsu_we_i = 1'($urandom);
        lsu_funct3_i = 3'($urandom);
        lsu_addr_i = $urandom;
        lsu_wdata_i = $urandom;
      end
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i = $urandom;
      if (dmem_req_o) begin
        dmem_gnt_i = (rq == v.gdly);
        rq++;
      end else if (granted != 0 && rv_done == 0) begin
        if (v.norv == 0 && wt == v.rdly) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i = v.rdata;
          rv_done = 1;
        end
        wt++;
      end
      #1;
      if (lsu_stall_o) o.stall++;
      if (dmem_req_o) begin
        if (o.req == 0) begin
          o.addr = dmem_addr_o;
          o.be = dmem_be_o;
          o.wd = dmem_wdata_o;
          o.we = dmem_we_o;
        end else if ({o.addr, o.be, o.wd, o.we} !==
                     {dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o}) begin
          o.unstable = 1;
        end
        o.req++;
        if (dmem_gnt_i) granted = 1;
      end
      if (ld_valid_o) begin
        o.ldv++;
        o.ld_pulse = ld_data_o;
      end
      if (misalign_o) o.mis++;
      if (bus_err_o) o.err++;
      if (pend == 0) tail++;
      if (pend != 0 && !lsu_stall_o) pend = 0;
      if (tail == 3) break;
    end
    o.hung = (tail < 3) ? 1 : 0;
    lsu_valid_i = 1'b0;
  endtask

  task automatic check_op(input string id, input vec_t v,
                          input exp_t e, input obs_t o);
    int ereq;
    int eldv;
    ereq = (e.mis != 0) ? 0 : v.gdly + 1;
    eldv = (e.mis == 0 && e.err == 0 && !v.we) ? 1 : 0;
    chk({id, ".done"}, o.hung, 0);
    chk({id, ".misalign"}, o.mis, e.mis);
    chk({id, ".bus_err"}, o.err, e.err);
    chk({id, ".stall_cycles"}, o.stall, e.stall);
    chk({id, ".req_cycles"}, o.req, ereq);
    chk({id, ".ld_valid"}, o.ldv, eldv);
    if (ereq > 0) begin
      chk({id, ".addr"}, o.addr, {v.addr[31:2], 2'b00});
      chk({id, ".we"}, 32'(o.we), 32'(v.we));
      chk({id, ".be"}, 32'(o.be), 32'(e.be));
      chk({id, ".req_stable"}, o.unstable, 0);
      if (v.we) chk({id, ".wdata"}, o.wd, e.wd);
    end
    if (eldv != 0) chk({id, ".ld_pulse"}, o.ld_pulse, e.ld);
    chk({id, ".ld_data"}, ld_data_o, e.ld);
  endtask

  row_t tbl[16];
  vec_t rv;
  exp_t re;
  obs_t ro;
  int   ldv_seen;
  int   req_seen;

  initial begin
    tbl[0]  = '{'{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0},
                '{0, 0, 3, 4'hF, 32'h0, 32'hDEADBEEF}};
    tbl[1]  = '{'{1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 0},
                '{0, 0, 3, 4'hF, 32'h0, 32'hFFFFFF80}};
    tbl[2]  = '{'{1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1, 0, 0},
                '{0, 0, 4, 4'hF, 32'h0, 32'h00000080}};
    tbl[3]  = '{'{1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 1, 0},
                '{0, 0, 4, 4'hF, 32'h0, 32'hFFFF8001}};
    tbl[4]  = '{'{1'b1, 3'b000, 32'h201, 32'hAB, 32'h0, 0, 0, 0},
                '{0, 0, 3, 4'b0010, 32'hABABABAB, 32'hFFFF8001}};
    tbl[5]  = '{'{1'b1, 3'b001, 32'h202, 32'h1234CAFE, 32'h0, 2, 0, 0},
                '{0, 0, 5, 4'b1100, 32'hCAFECAFE, 32'hFFFF8001}};
    tbl[6]  = '{'{1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0},
                '{1, 0, 1, 4'h0, 32'h0, 32'hFFFF8001}};
    tbl[7]  = '{'{1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 4, 2, 0},
                '{0, 0, 9, 4'hF, 32'h0, 32'h12345678}};
    tbl[8]  = '{'{1'b0, 3'b010, 32'h304, 32'h0, 32'h0, 1, 0, 1},
                '{0, 1, 23, 4'hF, 32'h0, 32'h12345678}};
    tbl[9]  = '{'{1'b1, 3'b010, 32'h400, 32'hA5A50F0F, 32'h0, 0, 1, 0},
                '{0, 0, 4, 4'hF, 32'hA5A50F0F, 32'h12345678}};
    tbl[10] = '{'{1'b0, 3'b101, 32'h106, 32'h0, 32'hFEDC0000, 0, 0, 0},
                '{0, 0, 3, 4'hF, 32'h0, 32'h0000FEDC}};
    tbl[11] = '{'{1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 0},
                '{1, 0, 1, 4'h0, 32'h0, 32'h0000FEDC}};
    tbl[12] = '{'{1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 0, 0, 0},
                '{1, 0, 1, 4'h0, 32'h0, 32'h0000FEDC}};
    tbl[13] = '{'{1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 0},
                '{1, 0, 1, 4'h0, 32'h0, 32'h0000FEDC}};
    tbl[14] = '{'{1'b1, 3'b000, 32'h203, 32'h5A, 32'h0, 0, 0, 0},
                '{0, 0, 3, 4'b1000, 32'h5A5A5A5A, 32'h0000FEDC}};
    tbl[15] = '{'{1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 0, 0},
                '{0, 0, 3, 4'hF, 32'h0, 32'h0000007F}};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("reset.stall", 32'(lsu_stall_o), 0);
    chk("reset.ld_data", ld_data_o, 0);
    chk("reset.ld_valid", 32'(ld_valid_o), 0);
    chk("reset.misalign", 32'(misalign_o), 0);
    chk("reset.bus_err", 32'(bus_err_o), 0);
    chk("reset.req", 32'(dmem_req_o), 0);
    chk("reset.we", 32'(dmem_we_o), 0);
    chk("reset.addr", dmem_addr_o, 0);
    chk("reset.wdata", dmem_wdata_o, 0);
    chk("reset.be", 32'(dmem_be_o), 0);

    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].v, ro);
      check_op($sformatf("vec%0d", i), tbl[i].v, tbl[i].e, ro);
      exp_ld = tbl[i].e.ld;
    end

    // reset while waiting for the response; the late ack is ignored
    @(negedge clk_i);
    lsu_valid_i = 1'b1;
    lsu_we_i = 1'b0;
    lsu_funct3_i = 3'b010;
    lsu_addr_i = 32'h500;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid.req", 32'(dmem_req_o), 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk("rst_mid.wait_stall", 32'(lsu_stall_o), 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    lsu_valid_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    #1;
    chk("rst_mid.stall", 32'(lsu_stall_o), 0);
    chk("rst_mid.req_dropped", 32'(dmem_req_o), 0);
    chk("rst_mid.ld_data", ld_data_o, 0);
    ldv_seen = 0;
    req_seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      #1;
      if (ld_valid_o) ldv_seen++;
      if (dmem_req_o) req_seen++;
    end
    chk("rst_mid.no_ld_valid", ldv_seen, 0);
    chk("rst_mid.no_req", req_seen, 0);
    chk("rst_mid.ld_data_after", ld_data_o, 0);
    exp_ld = 32'b0;

    for (int i = 0; i < 80; i++) begin
      rv.we = 1'($urandom_range(0, 1));
      rv.f3 = 3'($urandom_range(0, 7));
      rv.addr = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.gdly = $urandom_range(0, 3);
      rv.rdly = $urandom_range(0, 3);
      rv.norv = ($urandom_range(0, 9) == 0) ? 1 : 0;
      re = model(rv, exp_ld);
      run_op(rv, ro);
      check_op($sformatf("rnd%0d", i), rv, re, ro);
      exp_ld = re.ld;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
